// File: rtl/seg_pkg.sv
// Shared defaults and active-low gfedcba segment codes
// for the multiplexed hex display scanner.
package seg_pkg;

  localparam int NDIGITS_DEF  = 8;
  localparam int CLK_DIV_DEF  = 100000;
  localparam int DEBOUNCE_DEF = 1000000;
  localparam int LZ_BLANK_DEF = 1;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low
// seven-segment (gfedcba) decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_0;
    unique case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex display scanner with debounced
// freeze button and leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIGITS  = NDIGITS_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int LZ_BLANK = LZ_BLANK_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*NDIGITS-1:0] word,
  input  logic                 btn,
  output logic [7:0]           SEG,
  output logic [NDIGITS-1:0]   AN,
  output logic                 frozen
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [1:0]           sync_q;
  logic                 deb_q, deb_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic                 frozen_q, frozen_d;
  logic [4*NDIGITS-1:0] snap_q, snap_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  logic [7:0]           seg_q, seg_d;

  logic                 cnt_wrap;
  logic                 press;
  logic [NDIGITS-1:0]   lz;
  logic                 zero_acc;
  logic                 blank;
  logic [3:0]           nib;
  logic [6:0]           seg7;

  hex7seg u_hex7seg (
    .hex_i (nib),
    .seg_o (seg7)
  );

  always_comb begin
    cnt_wrap = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IW'(NDIGITS - 1)) ? '0
                                           : idx_q + 1'b1;
    end
  end

  // Bounce on the synchronised level restarts the count.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (dcnt_q == DW'(DEBOUNCE - 1)) begin
        deb_d = sync_q[1];
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
    press    = deb_d & ~deb_q;
    frozen_d = frozen_q ^ press;
    snap_d   = frozen_q ? snap_q : word;
  end

  // Decode from the value being loaded this cycle so a
  // freeze and the word it captures always agree.
  always_comb begin
    zero_acc = 1'b1;
    lz       = '0;
    nib      = '0;
    blank    = 1'b0;
    an_d     = '1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zero_acc = zero_acc & (snap_d[4*k +: 4] == 4'h0);
      lz[k]    = zero_acc;
    end
    for (int k = 0; k < NDIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib   = snap_d[4*k +: 4];
        blank = (LZ_BLANK != 0) && (k != 0) && lz[k];
      end
    end
    for (int k = 0; k < NDIGITS; k++) begin
      an_d[k] = ~((idx_q == IW'(k)) & ~blank);
    end
    seg_d = blank ? SEG_OFF : {1'b1, seg7};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sync_q   <= '0;
      deb_q    <= 1'b0;
      dcnt_q   <= '0;
      frozen_q <= 1'b0;
      snap_q   <= '0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sync_q   <= {sync_q[0], btn};
      deb_q    <= deb_d;
      dcnt_q   <= dcnt_d;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign AN     = an_q;
  assign SEG    = seg_q;
  assign frozen = frozen_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a
// scoreboard of expected AN/SEG per clock edge.
module tb_seg_scan_ctrl;

  localparam int ND  = 4;
  localparam int CD  = 4;
  localparam int DEB = 3;

  logic        clk;
  logic        reset;
  logic [15:0] word;
  logic        btn;
  logic [7:0]  SEG;
  logic [3:0]  AN;
  logic        frozen;

  int errors;
  int checks;
  int ecnt;

  logic [11:0] sbq[$];

  logic [6:0] lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan_ctrl #(
    .NDIGITS  (ND),
    .CLK_DIV  (CD),
    .DEBOUNCE (DEB),
    .LZ_BLANK (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .word   (word),
    .btn    (btn),
    .SEG    (SEG),
    .AN     (AN),
    .frozen (frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] exp_out(input int k,
                                          input logic [15:0] v);
    int d;
    logic [3:0] an;
    logic [3:0] nb;
    if (k <= 0) return {4'hF, 8'hFF};
    d  = ((k - 1) / CD) % ND;
    if (d > 0 && (v >> (4 * d)) == 16'h0) return {4'hF, 8'hFF};
    an    = 4'hF;
    an[d] = 1'b0;
    nb    = v[4*d +: 4];
    return {an, 1'b1, lut[nb]};
  endfunction

  task automatic scan_check(input logic [15:0] shown,
                            input int n,
                            input string tag);
    logic [11:0] e;
    @(negedge clk);
    sbq.push_back(exp_out(ecnt + 1, shown));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if ({AN, SEG} !== e) begin
        errors++;
        $display("FAIL %s edge %0d: AN=%b SEG=%b want AN=%b SEG=%b",
                 tag, ecnt, AN, SEG, e[11:8], e[7:0]);
      end
      if (i < n - 1) sbq.push_back(exp_out(ecnt + 1, shown));
    end
  endtask

  task automatic chk_frozen(input logic want, input string tag);
    checks++;
    if (frozen !== want) begin
      errors++;
      $display("FAIL %s: frozen=%b want %b", tag, frozen, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    btn   = 1'b0;
    word  = 16'h12AF;
    #12;
    checks++;
    if (AN !== 4'hF || SEG !== 8'hFF) begin
      errors++;
      $display("FAIL reset_out: AN=%b SEG=%h want 1111 ff", AN, SEG);
    end
    chk_frozen(1'b0, "reset_frozen");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_scan;
    scan_check(16'h12AF, 2 * ND * CD, "scan_12af");
  endtask

  task automatic test_zero;
    word = 16'h0000;
    scan_check(16'h0000, 2 * ND * CD, "scan_zero");
  endtask

  task automatic test_lz_blank;
    word = 16'h00F0;
    scan_check(16'h00F0, 2 * ND * CD, "lz_00f0");
  endtask

  task automatic test_freeze;
    word = 16'h12AF;
    @(negedge clk);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    chk_frozen(1'b0, "short_pulse");
    btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) chk_frozen(1'b0, "press1_early");
      if (i == 5) chk_frozen(1'b1, "press1_edge");
    end
    btn = 1'b0;
    repeat (8) @(negedge clk);
    chk_frozen(1'b1, "press1_release");
    word = 16'h5555;
    scan_check(16'h12AF, 2 * ND * CD, "frozen_hold");
    btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) chk_frozen(1'b1, "press2_early");
      if (i == 5) chk_frozen(1'b0, "press2_edge");
    end
    btn = 1'b0;
    repeat (8) @(negedge clk);
    chk_frozen(1'b0, "press2_release");
    word = 16'h3C4D;
    scan_check(16'h3C4D, 2 * ND * CD, "unfrozen_follow");
  endtask

  task automatic test_reset_mid;
    btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) chk_frozen(1'b1, "pre_reset_freeze");
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (AN !== 4'hF || SEG !== 8'hFF) begin
      errors++;
      $display("FAIL mid_reset_out: AN=%b SEG=%h want 1111 ff", AN, SEG);
    end
    chk_frozen(1'b0, "mid_reset_frozen");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (AN !== 4'b1110) begin
          errors++;
          $display("FAIL first_digit: AN=%b want 1110", AN);
        end
      end
      if (i == 4) chk_frozen(1'b0, "redebounce_early");
      if (i == 5) chk_frozen(1'b1, "redebounce_edge");
    end
    btn = 1'b0;
    scan_check(16'h3C4D, ND * CD, "post_reset_scan");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_scan();
    test_zero();
    test_lz_blank();
    test_freeze();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
